// File: rtl/wb_traffic_gen.sv
// Wishbone write-then-readback traffic generator for SDRAM bring-up.
// Optional bus watchdog enabled by defining WB_TG_TIMEOUT_EN.
module wb_traffic_gen #(
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 26,
  parameter int unsigned NUM_WORDS = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            start_i,
  input  logic            sdr_init_done_i,
  input  logic [AW-1:0]   base_addr_i,
  input  logic [DW-1:0]   seed_i,
  output logic [AW-1:0]   wb_addr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic            wb_stb_o,
  output logic            wb_cyc_o,
  input  logic            wb_ack_i,
  input  logic [DW-1:0]   wb_dat_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            pass_o,
  output logic [15:0]     err_cnt_o,
  output logic            timeout_o
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitInit,
    StWrite,
    StWgap,
    StRead,
    StRgap,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [AW-1:0] base_q;
  logic [DW-1:0] seed_q;
  logic [7:0]    idx_q;
  logic [15:0]   err_q;
  logic          done_q;

  logic          start_acc;
  logic          in_xfer;
  logic          last_word;
  logic          wdog_expire;
  logic [DW-1:0] cur_dat;

  assign start_acc = start_i && ((state_q == StIdle) || (state_q == StDone));
  assign in_xfer   = (state_q == StWrite) || (state_q == StRead);
  assign last_word = (idx_q == 8'(NUM_WORDS - 1));
  assign cur_dat   = seed_q + DW'(idx_q);

`ifdef WB_TG_TIMEOUT_EN
  logic [7:0] wdog_q;
  logic       timeout_q;

  // Counter restarts every transaction; expiry lands on the 255th unacked strobe cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (!in_xfer || wb_ack_i) begin
        wdog_q <= '0;
      end else begin
        wdog_q <= wdog_q + 8'd1;
      end
      if (start_acc) begin
        timeout_q <= 1'b0;
      end else if (wdog_expire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign wdog_expire = in_xfer && !wb_ack_i && (wdog_q == 8'd254);
  assign timeout_o   = timeout_q;
`else
  assign wdog_expire = 1'b0;
  assign timeout_o   = 1'b0;
`endif

  // State register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start_acc) state_d = StWaitInit;
      end
      StWaitInit: begin
        if (sdr_init_done_i) state_d = StWrite;
      end
      StWrite: begin
        if (wdog_expire) begin
          state_d = StDone;
        end else if (wb_ack_i) begin
          state_d = StWgap;
        end
      end
      StWgap: begin
        state_d = last_word ? StRead : StWrite;
      end
      StRead: begin
        if (wdog_expire) begin
          state_d = StDone;
        end else if (wb_ack_i) begin
          state_d = StRgap;
        end
      end
      StRgap: begin
        state_d = last_word ? StDone : StRead;
      end
      StDone: begin
        if (start_acc) state_d = StWaitInit;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    wb_stb_o = 1'b0;
    wb_we_o  = 1'b0;
    busy_o   = 1'b0;
    case (state_q)
      StWrite: begin
        wb_stb_o = 1'b1;
        wb_we_o  = 1'b1;
        busy_o   = 1'b1;
      end
      StRead: begin
        wb_stb_o = 1'b1;
        busy_o   = 1'b1;
      end
      StWaitInit, StWgap, StRgap: busy_o = 1'b1;
      default: ;
    endcase
    wb_cyc_o = wb_stb_o;
    wb_sel_o = {(DW/8){wb_stb_o}};
  end

  // Word index advances during the gap so the ack cycle still sees the acked word.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      base_q <= '0;
      seed_q <= '0;
      idx_q  <= '0;
      err_q  <= '0;
      done_q <= 1'b0;
    end else if (start_acc) begin
      base_q <= base_addr_i;
      seed_q <= seed_i;
      idx_q  <= '0;
      err_q  <= '0;
      done_q <= 1'b0;
    end else begin
      if (state_q == StWgap) begin
        idx_q <= last_word ? 8'd0 : idx_q + 8'd1;
      end
      if ((state_q == StRgap) && !last_word) begin
        idx_q <= idx_q + 8'd1;
      end
      if ((state_q == StRead) && wb_ack_i && (wb_dat_i != cur_dat) && (err_q != 16'hFFFF)) begin
        err_q <= err_q + 16'd1;
      end
      if ((state_d == StDone) && (state_q != StDone)) begin
        done_q <= 1'b1;
      end
    end
  end

  assign wb_addr_o = base_q + AW'({idx_q, 2'b00});
  assign wb_dat_o  = cur_dat;
  assign done_o    = done_q;
  assign err_cnt_o = err_q;
  assign pass_o    = done_q && (err_q == 16'd0) && !timeout_o;

endmodule

// File: tb/tb_wb_traffic_gen.sv
// Randomized bench for wb_traffic_gen: Wishbone memory slave with variable ack delay and
// read corruption, checked against an address/data model built from the word formulas.
module tb_wb_traffic_gen;

  localparam int DW = 32;
  localparam int AW = 26;
  localparam int N  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            init = 1'b1;
  logic [AW-1:0]   base = '0;
  logic [DW-1:0]   seed = '0;
  logic [AW-1:0]   addr_o;
  logic [DW-1:0]   dat_o;
  logic [DW/8-1:0] sel_o;
  logic            we_o, stb_o, cyc_o;
  logic            ack = 1'b0;
  logic [DW-1:0]   rdat = '0;
  logic            busy_o, done_o, pass_o, timeout_o;
  logic [15:0]     err_o;

  wb_traffic_gen #(.DW(DW), .AW(AW), .NUM_WORDS(N)) dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .start_i         (start),
    .sdr_init_done_i (init),
    .base_addr_i     (base),
    .seed_i          (seed),
    .wb_addr_o       (addr_o),
    .wb_dat_o        (dat_o),
    .wb_sel_o        (sel_o),
    .wb_we_o         (we_o),
    .wb_stb_o        (stb_o),
    .wb_cyc_o        (cyc_o),
    .wb_ack_i        (ack),
    .wb_dat_i        (rdat),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .pass_o          (pass_o),
    .err_cnt_o       (err_o),
    .timeout_o       (timeout_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
    logic          we;
  } txn_t;

  txn_t          txq[$];
  logic [DW-1:0] mem[logic [AW-1:0]];
  int            max_delay = 0;
  int            corrupt = 0;
  int            rd_idx = 0;
  bit            spur_en = 1'b1;
  bit            no_ack = 1'b0;
  int            bus_viol = 0;
  int            gap_viol = 0;

  // Memory slave plus bus-protocol monitor, all sampled on the falling edge.
  initial begin : slave
    int   wcnt;
    int   dly;
    bit   acked_prev;
    bit   hold;
    txn_t prev;
    txn_t t;
    wcnt = 0; dly = 0; acked_prev = 1'b0; hold = 1'b0;
    forever begin
      @(negedge clk);
      ack = 1'b0;
      if (rst) begin
        wcnt = 0; acked_prev = 1'b0; hold = 1'b0;
        continue;
      end
      if (stb_o) begin
        if (acked_prev) gap_viol++;
        if (cyc_o !== 1'b1 || sel_o !== '1) bus_viol++;
        t.addr = addr_o; t.dat = dat_o; t.we = we_o;
        if (hold && (t.addr !== prev.addr || t.dat !== prev.dat || t.we !== prev.we)) bus_viol++;
        if (!no_ack && wcnt >= dly) begin
          ack = 1'b1; acked_prev = 1'b1; hold = 1'b0; wcnt = 0;
          dly = $urandom_range(max_delay, 0);
          txq.push_back(t);
          if (t.we) begin
            mem[t.addr] = t.dat;
          end else begin
            rdat = mem.exists(t.addr) ? mem[t.addr] : '0;
            if (corrupt[rd_idx]) rdat = rdat ^ 32'h0000_0100;
            rd_idx++;
          end
        end else begin
          wcnt++; hold = 1'b1; prev = t; acked_prev = 1'b0;
        end
      end else begin
        acked_prev = 1'b0; hold = 1'b0;
        if (cyc_o !== 1'b0) bus_viol++;
        if (spur_en && $urandom_range(3, 0) == 0) ack = 1'b1;
      end
    end
  end

  task automatic pulse_start(input logic [AW-1:0] b, input logic [DW-1:0] s);
    base = b; seed = s;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    base = AW'($urandom); seed = $urandom;
  endtask

  task automatic run_pass(input string nm, input logic [AW-1:0] b, input logic [DW-1:0] s,
                          input int cmask, input int md, input int init_wait,
                          input bit chk_lat, input bit poke);
    int            cyc, first, done_at, stb_wait, busy_low, exp_err;
    bit            got_done;
    logic [AW-1:0] ea;
    cyc = 0; first = -1; done_at = -1; stb_wait = 0; busy_low = 0; got_done = 1'b0;
    txq.delete(); rd_idx = 0; corrupt = cmask; max_delay = md; bus_viol = 0; gap_viol = 0;
    init = (init_wait == 0);
    pulse_start(b, s);
    check({nm, "_busy_start"}, 64'(busy_o), 64'd1);
    check({nm, "_done_clr"}, 64'(done_o), 64'd0);
    for (int i = 0; i < init_wait; i++) begin
      @(negedge clk);
      if (stb_o) stb_wait++;
      if (!busy_o) busy_low++;
    end
    if (init_wait > 0) begin
      check({nm, "_stb_in_wait"}, 64'(stb_wait), 64'd0);
      check({nm, "_busy_in_wait"}, 64'(busy_low), 64'd0);
      init = 1'b1;
    end
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      cyc++;
      if (poke) start = (cyc == 7);
      if (stb_o && first < 0) first = cyc;
      if (done_o) begin
        got_done = 1'b1; done_at = cyc;
        break;
      end
    end
    start = 1'b0;
    check({nm, "_done"}, 64'(got_done), 64'd1);
    if (chk_lat) check({nm, "_latency"}, 64'(done_at - first), 64'(2 * N * 2));
    check({nm, "_ntxn"}, 64'(txq.size()), 64'(2 * N));
    for (int i = 0; i < txq.size() && i < 2 * N; i++) begin
      ea = AW'((64'(b) + 64'(4 * (i % N))) % (64'd1 << AW));
      check($sformatf("%s_addr%0d", nm, i), 64'(txq[i].addr), 64'(ea));
      check($sformatf("%s_we%0d", nm, i), 64'(txq[i].we), 64'(i < N));
      if (i < N) check($sformatf("%s_wdat%0d", nm, i), 64'(txq[i].dat), 64'(DW'(s + DW'(i))));
    end
    exp_err = $countones(cmask[N-1:0]);
    check({nm, "_err_cnt"}, 64'(err_o), 64'(exp_err));
    check({nm, "_pass"}, 64'(pass_o), 64'(exp_err == 0));
    check({nm, "_busy_end"}, 64'(busy_o), 64'd0);
    check({nm, "_timeout"}, 64'(timeout_o), 64'd0);
    check({nm, "_bus_viol"}, 64'(bus_viol), 64'd0);
    check({nm, "_gap_viol"}, 64'(gap_viol), 64'd0);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_stb"}, 64'(stb_o), 64'd0);
    check({nm, "_cyc"}, 64'(cyc_o), 64'd0);
    check({nm, "_we"}, 64'(we_o), 64'd0);
    check({nm, "_sel"}, 64'(sel_o), 64'd0);
    check({nm, "_addr"}, 64'(addr_o), 64'd0);
    check({nm, "_dat"}, 64'(dat_o), 64'd0);
    check({nm, "_busy"}, 64'(busy_o), 64'd0);
    check({nm, "_done"}, 64'(done_o), 64'd0);
    check({nm, "_pass"}, 64'(pass_o), 64'd0);
    check({nm, "_errcnt"}, 64'(err_o), 64'd0);
    check({nm, "_timeout"}, 64'(timeout_o), 64'd0);
  endtask

  initial begin : main
    int            act;
    bit            hit;
    logic [AW-1:0] rb;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    act = 0;
    repeat (10) begin
      @(negedge clk);
      if (stb_o || busy_o) act++;
    end
    check("idle_no_activity", 64'(act), 64'd0);

    run_pass("basic", 26'h100, 32'hA5A5_0000, 0, 0, 0, 1'b1, 1'b0);
    run_pass("corrupt2", 26'h100, 32'hA5A5_0000, 32'h4, 0, 0, 1'b1, 1'b0);
    run_pass("initwait", 26'h100, 32'hA5A5_0000, 0, 0, 50, 1'b0, 1'b0);
    run_pass("slow", 26'h200, 32'h1234_5678, 0, 3, 0, 1'b0, 1'b1);
    run_pass("wrap", 26'h3FF_FFF8, 32'hFFFF_FFFE, 32'h9, 2, 0, 1'b0, 1'b0);
    for (int r = 0; r < 5; r++) begin
      rb = AW'($urandom) & ~AW'(3);
      run_pass($sformatf("rand%0d", r), rb, $urandom, int'($urandom_range(15, 0)),
               int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), 1'b0, r[0]);
    end

`ifdef WB_TG_TIMEOUT_EN
    no_ack = 1'b1; init = 1'b1; act = 0; hit = 1'b0;
    pulse_start(26'h40, 32'h0);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (stb_o) begin
        act++;
      end else if (act > 0) begin
        hit = 1'b1;
        break;
      end
    end
    no_ack = 1'b0;
    check("wdog_dropped", 64'(hit), 64'd1);
    check("wdog_stb_cycles", 64'(act), 64'd255);
    check("wdog_timeout", 64'(timeout_o), 64'd1);
    check("wdog_done", 64'(done_o), 64'd1);
    check("wdog_pass", 64'(pass_o), 64'd0);
    run_pass("after_wdog", 26'h80, 32'h55, 0, 1, 0, 1'b0, 1'b0);
`endif

    // Reset in the middle of the third write, asserted away from any clock edge.
    txq.delete(); rd_idx = 0; corrupt = 0; max_delay = 2; init = 1'b1; hit = 1'b0;
    pulse_start(26'h300, 32'hCAFE_0000);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (stb_o && we_o && addr_o == 26'h308) begin
        hit = 1'b1;
        break;
      end
    end
    check("rst3_reached", 64'(hit), 64'd1);
    #1 rst = 1'b1;
    #1 check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    run_pass("after_rst", 26'h300, 32'hCAFE_0000, 0, 1, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_traffic_gen.md
WB_TRAFFIC_GEN -- requirements
Module: wb_traffic_gen

Interface
REQ-001 Parameter DW, default 32, Wishbone data width in bits.
REQ-002 Parameter AW, default 26, Wishbone byte-address width in bits.
REQ-003 Parameter NUM_WORDS, default 16, words per test pass; legal range 1..256.
REQ-004 Port wb_clk_i, input, 1, sole clock; all state updates on its rising edge.
REQ-005 Port wb_rst_i, input, 1, reset, asynchronous, active-high.
REQ-006 Port start_i, input, 1, single-cycle request to begin a test pass.
REQ-007 Port sdr_init_done_i, input, 1, SDRAM controller initialisation complete.
REQ-008 Port base_addr_i, input, AW, byte start address; sampled on accepted start.
REQ-009 Port seed_i, input, DW, data pattern seed; sampled on accepted start.
REQ-010 Port wb_addr_o, output, AW, Wishbone byte address.
REQ-011 Port wb_dat_o, output, DW, Wishbone write data.
REQ-012 Port wb_sel_o, output, DW/8, byte enables; all ones whenever wb_stb_o=1.
REQ-013 Port wb_we_o, output, 1, write enable.
REQ-014 Port wb_stb_o and wb_cyc_o, output, 1 each, strobe and cycle; always equal.
REQ-015 Port wb_ack_i, input, 1, slave acknowledge.
REQ-016 Port wb_dat_i, input, DW, read data; valid when wb_ack_i=1 and wb_we_o=0.
REQ-017 Port busy_o, output, 1, high from accepted start until DONE.
REQ-018 Port done_o, output, 1, sticky completion flag; cleared by next accepted start.
REQ-019 Port pass_o, output, 1, high with done_o when err_cnt_o=0.
REQ-020 Port err_cnt_o, output, 16, read miscompare count, saturating at 16'hFFFF.
REQ-021 Port timeout_o, output, 1, sticky watchdog abort flag (see Configuration).

Function
REQ-022 States: IDLE, WAIT_INIT, WRITE, WGAP, READ, RGAP, DONE.
REQ-023 IDLE: start_i=1 latches base/seed, clears idx, err_cnt_o, done_o, pass_o and timeout_o, then goes to WAIT_INIT; start_i is ignored in every other state except DONE.
REQ-024 WAIT_INIT -> WRITE on the first cycle sdr_init_done_i=1; WRITE is entered in the same cycle if it is already high.
REQ-025 Word k (0..NUM_WORDS-1): address = base + 4*k, modulo 2^AW; data = seed + k, modulo 2^DW.
REQ-026 WRITE/READ: stb/cyc held high with stable addr/dat/we until wb_ack_i=1; wb_we_o=1 in WRITE and 0 in READ.
REQ-027 On ack, the next cycle drops stb/cyc for exactly one cycle (WGAP/RGAP); the next transaction follows; stb is never high two cycles across an ack.
REQ-028 After the ack for word NUM_WORDS-1 in WRITE: WGAP, then READ with idx=0.
REQ-029 READ ack: wb_dat_i != seed+idx increments err_cnt_o (saturating) in the following cycle.
REQ-030 After the ack for the last READ word: RGAP, then DONE; done_o=1, busy_o=0, pass_o=(err_cnt_o==0).
REQ-031 DONE: start_i=1 behaves as in IDLE (re-arm); outputs otherwise hold.
REQ-032 wb_ack_i while stb=0 is ignored.
REQ-033 Minimum pass latency with 1-cycle ack: 2*NUM_WORDS*2 cycles from WRITE entry to DONE.

Reset
REQ-034 wb_rst_i=1 forces state IDLE, idx 0, and all outputs 0 (including wb_stb_o/wb_cyc_o, which drop asynchronously mid-transaction).
REQ-035 After reset release, no bus activity occurs until an accepted start.

Configuration
REQ-036 Macro WB_TG_TIMEOUT_EN defined: an 8-bit watchdog counts cycles with stb=1 and no ack; on reaching 255, stb/cyc drop, timeout_o=1, pass_o=0, and the FSM enters DONE.
REQ-037 Macro WB_TG_TIMEOUT_EN not defined: no watchdog; timeout_o is tied to 0; stb is held indefinitely.

Verification
REQ-038 NUM_WORDS=4, base=0x100, seed=0xA5A5_0000, ideal memory with 1-cycle ack -> writes 0x100/0x104/0x108/0x10C with data 0xA5A5_0000..0003, then 4 reads; done_o=1, pass_o=1, err_cnt_o=0.
REQ-039 Same setup, memory corrupts read word 2 -> err_cnt_o=1, pass_o=0.
REQ-040 sdr_init_done_i held low 50 cycles after start -> no stb until it rises; busy_o=1 throughout.
REQ-041 Ack delayed 3 cycles per transaction -> addr/dat/we stable while stb is high; a one-cycle stb gap follows each ack.
REQ-042 wb_rst_i asserted during the 3rd write -> stb/cyc low in the same cycle, all outputs 0; a later start runs a full pass and ends with pass_o=1.
REQ-043 WB_TG_TIMEOUT_EN defined, ack never returned -> stb drops after 255 cycles; timeout_o=1, done_o=1, pass_o=0.
